// File: rtl/dma_port_arb_if.sv
// Irdy/Trdy memory-request handshake shared by the DMA requesters and the memory engine.
// master issues the request and attributes; slave answers with trdy/err.
interface dma_port_arb_if #(
  parameter int SBASE = 1,
  parameter int AW    = 28
);
  logic             irdy;
  logic             rd_wr;
  logic [AW-1:0]    add;
  logic             bank;
  logic [SBASE:0]   size;
  logic             trdy;
  logic             err;

  modport master (output irdy, rd_wr, add, bank, size, input trdy, err);
  modport slave  (input irdy, rd_wr, add, bank, size, output trdy, err);
endinterface

// File: rtl/dma_port_arb.sv
// Round-robin arbiter letting two requesters share one DMA memory port.
// Attributes are latched at grant so each transfer is atomic toward memory.
module dma_port_arb #(
  parameter int SBASE = 1,
  parameter int AW    = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  dma_port_arb_if.slave         m0,
  dma_port_arb_if.slave         m1,
  dma_port_arb_if.master        mem,
  output logic [1:0]            gnt,
  output logic                  arb_idle
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [1:0]      r_gnt;
  logic            r_last;
  logic            r_mem_irdy;
  logic            r_mem_rd_wr;
  logic [AW-1:0]   r_mem_add;
  logic            r_mem_bank;
  logic [SBASE:0]  r_mem_size;

  logic [1:0]      w_irdy;
  logic            w_grant;
  logic            w_sel;
  logic            w_release;
  logic [1:0]      w_trdy;
  logic [1:0]      w_err;

  assign w_irdy = {m1.irdy, m0.irdy};

  // Completion is forwarded only to the current owner, and only while BUSY.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign w_trdy[gi] = (r_state == BUSY) & r_gnt[gi] & mem.trdy;
    assign w_err[gi]  = w_trdy[gi] & mem.err;
  end

  assign m0.trdy = w_trdy[0];
  assign m0.err  = w_err[0];
  assign m1.trdy = w_trdy[1];
  assign m1.err  = w_err[1];

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_sel        = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_irdy) begin
          w_grant      = 1'b1;
          // On a tie the requester that did not own the last transfer wins.
          w_sel        = (&w_irdy) ? ~r_last : w_irdy[1];
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        if (mem.trdy) begin
          w_release    = 1'b1;
          w_state_next = DRAIN;
        end
      end
      DRAIN:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_gnt       <= 2'b00;
      r_last      <= 1'b1;
      r_mem_irdy  <= 1'b0;
      r_mem_rd_wr <= 1'b0;
      r_mem_add   <= '0;
      r_mem_bank  <= 1'b0;
      r_mem_size  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_gnt       <= w_sel ? 2'b10 : 2'b01;
        r_mem_irdy  <= 1'b1;
        r_mem_rd_wr <= w_sel ? m1.rd_wr : m0.rd_wr;
        r_mem_add   <= w_sel ? m1.add   : m0.add;
        r_mem_bank  <= w_sel ? m1.bank  : m0.bank;
        r_mem_size  <= w_sel ? m1.size  : m0.size;
      end
      if (w_release) begin
        r_gnt      <= 2'b00;
        r_mem_irdy <= 1'b0;
        r_last     <= r_gnt[1];
      end
    end
  end

  assign mem.irdy  = r_mem_irdy;
  assign mem.rd_wr = r_mem_rd_wr;
  assign mem.add   = r_mem_add;
  assign mem.bank  = r_mem_bank;
  assign mem.size  = r_mem_size;
  assign gnt       = r_gnt;
  assign arb_idle  = (r_state == IDLE);

endmodule

// File: tb/tb_dma_port_arb.sv
// Self-checking bench for dma_port_arb: directed plan steps followed by random traffic,
// all compared against a transaction-level reference model.
module tb_dma_port_arb;
  localparam int SBASE = 1;
  localparam int AW    = 28;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] gnt;
  logic       arb_idle;

  dma_port_arb_if #(.SBASE(SBASE), .AW(AW)) m0_if ();
  dma_port_arb_if #(.SBASE(SBASE), .AW(AW)) m1_if ();
  dma_port_arb_if #(.SBASE(SBASE), .AW(AW)) mem_if ();

  dma_port_arb #(.SBASE(SBASE), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .m0       (m0_if.slave),
    .m1       (m1_if.slave),
    .mem      (mem_if.master),
    .gnt      (gnt),
    .arb_idle (arb_idle)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the port (-1 = nobody), who owned it last,
  // whether we are in the one-cycle cool-down after a completion, and the
  // attributes captured at grant.
  int             mdl_owner;
  int             mdl_last;
  bit             mdl_cool;
  logic           mdl_rd_wr;
  logic [AW-1:0]  mdl_add;
  logic           mdl_bank;
  logic [SBASE:0] mdl_size;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void mdl_reset();
    mdl_owner = -1;
    mdl_last  = 1;
    mdl_cool  = 1'b0;
    mdl_rd_wr = 1'b0;
    mdl_add   = '0;
    mdl_bank  = 1'b0;
    mdl_size  = '0;
  endfunction

  // One clock edge of the arbitration rules, using the inputs present at that edge.
  function automatic void mdl_edge();
    int win;
    win = -1;
    if (mdl_owner >= 0) begin
      if (mem_if.trdy === 1'b1) begin
        mdl_last  = mdl_owner;
        mdl_owner = -1;
        mdl_cool  = 1'b1;
      end
    end else if (mdl_cool) begin
      mdl_cool = 1'b0;
    end else begin
      if (m0_if.irdy && m1_if.irdy) win = (mdl_last == 0) ? 1 : 0;
      else if (m0_if.irdy)          win = 0;
      else if (m1_if.irdy)          win = 1;
      if (win == 0) begin
        mdl_rd_wr = m0_if.rd_wr; mdl_add = m0_if.add; mdl_bank = m0_if.bank; mdl_size = m0_if.size;
      end else if (win == 1) begin
        mdl_rd_wr = m1_if.rd_wr; mdl_add = m1_if.add; mdl_bank = m1_if.bank; mdl_size = m1_if.size;
      end
      mdl_owner = win;
    end
  endfunction

  task automatic chk_regs(input string tag);
    logic [1:0] eg;
    eg = (mdl_owner < 0) ? 2'b00 : ((mdl_owner == 0) ? 2'b01 : 2'b10);
    chk({tag, "_gnt"},      gnt,          eg);
    chk({tag, "_mem_irdy"}, mem_if.irdy,  mdl_owner >= 0);
    chk({tag, "_rd_wr"},    mem_if.rd_wr, mdl_rd_wr);
    chk({tag, "_add"},      mem_if.add,   mdl_add);
    chk({tag, "_bank"},     mem_if.bank,  mdl_bank);
    chk({tag, "_size"},     mem_if.size,  mdl_size);
    chk({tag, "_idle"},     arb_idle,     (mdl_owner < 0) && !mdl_cool);
  endtask

  task automatic chk_comb(input string tag);
    bit t0, t1;
    t0 = (mdl_owner == 0) && (mem_if.trdy === 1'b1);
    t1 = (mdl_owner == 1) && (mem_if.trdy === 1'b1);
    chk({tag, "_m0_trdy"}, m0_if.trdy, t0);
    chk({tag, "_m1_trdy"}, m1_if.trdy, t1);
    chk({tag, "_m0_err"},  m0_if.err,  t0 && (mem_if.err === 1'b1));
    chk({tag, "_m1_err"},  m1_if.err,  t1 && (mem_if.err === 1'b1));
  endtask

  task automatic step(input string tag);
    #1;
    chk_comb(tag);
    @(posedge clk);
    mdl_edge();
    #1;
    chk_regs(tag);
    $display("[TB] %s gnt=%b mem_irdy=%b mem_add=%h idle=%b", tag, gnt, mem_if.irdy, mem_if.add, arb_idle);
  endtask

  task automatic set_req(input int k, input bit irdy, input bit rd, input logic [AW-1:0] add,
                         input bit bank, input logic [SBASE:0] size);
    if (k == 0) begin
      m0_if.irdy = irdy; m0_if.rd_wr = rd; m0_if.add = add; m0_if.bank = bank; m0_if.size = size;
    end else begin
      m1_if.irdy = irdy; m1_if.rd_wr = rd; m1_if.add = add; m1_if.bank = bank; m1_if.size = size;
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    mdl_reset();
    chk_regs(tag);
    chk_comb(tag);
    @(posedge clk);
    #1;
    chk_regs(tag);
    rst = 1'b1;
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (mem_if.irdy !== 1'b1 && n < 10) begin
      step(tag);
      n++;
    end
    chk({tag, "_grant_timeout"}, (n < 10), 1'b1);
  endtask

  initial begin
    set_req(0, 0, 0, '0, 0, '0);
    set_req(1, 0, 0, '0, 0, '0);
    mem_if.trdy = 1'b0;
    mem_if.err  = 1'b0;

    // Plan 1 and 5: single request, completion, stale irdy held through DRAIN.
    do_reset("p1_rst");
    set_req(0, 1, 1, 28'h0000100, 0, 2'd3);
    step("p1_req");
    chk("p1_gnt", gnt, 2'b01);
    chk("p1_add", mem_if.add, 28'h0000100);
    chk("p1_size", mem_if.size, 2'd3);
    mem_if.trdy = 1'b1;
    #1;
    chk("p1_m0_trdy", m0_if.trdy, 1'b1);
    step("p1_done");
    mem_if.trdy = 1'b0;
    chk("p1_irdy_low", mem_if.irdy, 1'b0);
    step("p5_drain");
    chk("p5_no_regrant", gnt, 2'b00);
    chk("p5_idle", arb_idle, 1'b1);
    set_req(0, 0, 1, 28'h0000100, 0, 2'd3);
    step("p5_idle2");
    chk("p5_still_idle", gnt, 2'b00);

    // Plan 2 and 3: both requesting continuously; error on requester 1.
    do_reset("p2_rst");
    set_req(0, 1, 0, 28'h0000AAA, 1, 2'd1);
    set_req(1, 1, 1, 28'h0000BBB, 0, 2'd2);
    for (int t = 0; t < 4; t++) begin
      wait_grant("p2_wait");
      chk("p2_gnt_seq", gnt, (t % 2 == 0) ? 2'b01 : 2'b10);
      step("p2_busy");
      mem_if.trdy = 1'b1;
      mem_if.err  = (t == 1);
      #1;
      chk("p2_m1_trdy", m1_if.trdy, (t % 2 == 1));
      chk("p2_m0_trdy", m0_if.trdy, (t % 2 == 0));
      if (t == 1) begin
        chk("p3_m1_err", m1_if.err, 1'b1);
        chk("p3_m0_err", m0_if.err, 1'b0);
      end
      if (t == 3) chk("p3_m1_err_clr", m1_if.err, 1'b0);
      step("p2_done");
      mem_if.trdy = 1'b0;
      mem_if.err  = 1'b0;
    end

    // Plan 4: owner withdraws and changes attributes while BUSY.
    set_req(1, 0, 0, '0, 0, '0);
    set_req(0, 1, 1, 28'h0123456, 1, 2'd2);
    wait_grant("p4_wait");
    step("p4_busy0");
    set_req(0, 0, 0, 28'hFFFFFFF, 0, 2'd0);
    for (int i = 0; i < 3; i++) step("p4_busy");
    chk("p4_add_held", mem_if.add, 28'h0123456);
    chk("p4_irdy_held", mem_if.irdy, 1'b1);
    mem_if.trdy = 1'b1;
    #1;
    chk("p4_m0_trdy", m0_if.trdy, 1'b1);
    step("p4_done");
    mem_if.trdy = 1'b0;
    step("p4_drain");

    // Plan 6: asynchronous reset in BUSY with requester 1 owning.
    set_req(1, 1, 1, 28'h0000777, 1, 2'd1);
    wait_grant("p6_wait");
    chk("p6_gnt_m1", gnt, 2'b10);
    #2;
    rst = 1'b0;
    #1;
    chk("p6_async_gnt", gnt, 2'b00);
    chk("p6_async_irdy", mem_if.irdy, 1'b0);
    mdl_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_req(0, 1, 0, 28'h0000555, 0, 2'd0);
    step("p6_rel");
    chk("p6_gnt_m0", gnt, 2'b01);

    // Random traffic, including stray trdy/err outside BUSY.
    for (int c = 0; c < 600; c++) begin
      set_req(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1), AW'($urandom),
              $urandom_range(0, 1), (SBASE+1)'($urandom_range(0, 3)));
      set_req(1, ($urandom_range(0, 3) != 0), $urandom_range(0, 1), AW'($urandom),
              $urandom_range(0, 1), (SBASE+1)'($urandom_range(0, 3)));
      mem_if.trdy = ($urandom_range(0, 3) == 0);
      mem_if.err  = $urandom_range(0, 1);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
